// File: rtl/board_cursor_ctrl.sv
// Push-button front end for the checkers game: debounced 8x8 cursor plus committed select_loc.
// Optional macro BOARD_CURSOR_LEGAL_FILTER_EN restricts destination commits to legal_move slots.
//
// state | meaning
// PICK  | waiting for a select press on an occupied square (piece to move)
// DEST  | waiting for a select press on the destination square
// WAIT  | game logic rewriting the board; select presses refused until settle count expires
module board_cursor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_up_n,
    input  logic         key_down_n,
    input  logic         key_left_n,
    input  logic         key_right_n,
    input  logic         key_sel_n,
    input  logic [191:0] serialized_board,
    input  logic [27:0]  legal_move,
    output logic [5:0]   cursor_loc,
    output logic [5:0]   select_loc,
    output logic [1:0]   phase,
    output logic         commit_pulse,
    output logic         reject_pulse
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_RELOAD = ST_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PICK = 2'd0,
        DEST = 2'd1,
        WAIT = 2'd2
    } phase_t;

    logic [4:0] keys_n;
    logic [4:0] press;

    assign keys_n = {key_sel_n, key_right_n, key_left_n, key_down_n, key_up_n};

    for (genvar k = 0; k < 5; k++) begin : g_db
        logic            sync1;
        logic            sync2;
        logic            level;
        logic [DB_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
                level <= 1'b1;
                cnt   <= DB_RELOAD;
            end else begin
                sync1 <= keys_n[k];
                sync2 <= sync1;
                if (sync2 == level) begin
                    cnt <= DB_RELOAD;
                end else if (cnt == '0) begin
                    level <= sync2;
                    cnt   <= DB_RELOAD;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end

        // High on the cycle the accepted level falls, so consumers act on the same edge
        assign press[k] = level & ~sync2 & (cnt == '0);
    end

    logic press_up, press_down, press_left, press_right, press_sel;
    assign press_up    = press[0];
    assign press_down  = press[1];
    assign press_left  = press[2];
    assign press_right = press[3];
    assign press_sel   = press[4];

    logic [2:0] cur_x, cur_y, x_next, y_next;
    assign cur_x = cursor_loc[5:3];
    assign cur_y = cursor_loc[2:0];

    always_comb begin
        x_next = cur_x;
        y_next = cur_y;
        if (press_right && !press_left && cur_x != 3'd7)
            x_next = cur_x + 3'd1;
        else if (press_left && !press_right && cur_x != 3'd0)
            x_next = cur_x - 3'd1;
        if (press_up && !press_down && cur_y != 3'd7)
            y_next = cur_y + 3'd1;
        else if (press_down && !press_up && cur_y != 3'd0)
            y_next = cur_y - 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cursor_loc <= 6'd0;
        else
            cursor_loc <= {x_next, y_next};
    end

    logic [63:0] occupied;
    for (genvar sq = 0; sq < 64; sq++) begin : g_occ
        assign occupied[sq] = serialized_board[3*sq+2];
    end

    logic unused_board;
    assign unused_board = ^serialized_board;

`ifdef BOARD_CURSOR_LEGAL_FILTER_EN
    logic legal_hit;
    always_comb begin
        legal_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (legal_move[7*i+6] && legal_move[7*i +: 6] == cursor_loc)
                legal_hit = 1'b1;
        end
    end
`else
    logic unused_legal;
    assign unused_legal = ^legal_move;
`endif

    phase_t          state;
    logic [ST_W-1:0] settle_cnt;

    assign phase = state;

    // select_loc holds the picked origin while in DEST, so no separate origin register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= PICK;
            select_loc   <= 6'd0;
            commit_pulse <= 1'b0;
            reject_pulse <= 1'b0;
            settle_cnt   <= '0;
        end else begin
            commit_pulse <= 1'b0;
            reject_pulse <= 1'b0;
            case (state)
                PICK: begin
                    if (press_sel) begin
                        if (occupied[cursor_loc]) begin
                            select_loc   <= cursor_loc;
                            commit_pulse <= 1'b1;
                            state        <= DEST;
                        end else begin
                            reject_pulse <= 1'b1;
                        end
                    end
                end
                DEST: begin
                    if (press_sel) begin
`ifdef BOARD_CURSOR_LEGAL_FILTER_EN
                        if (cursor_loc == select_loc) begin
                            state <= PICK;
                        end else if (legal_hit) begin
                            select_loc   <= cursor_loc;
                            commit_pulse <= 1'b1;
                            state        <= WAIT;
                            settle_cnt   <= ST_RELOAD;
                        end else begin
                            reject_pulse <= 1'b1;
                        end
`else
                        select_loc   <= cursor_loc;
                        commit_pulse <= 1'b1;
                        state        <= WAIT;
                        settle_cnt   <= ST_RELOAD;
`endif
                    end
                end
                WAIT: begin
                    if (press_sel)
                        reject_pulse <= 1'b1;
                    if (settle_cnt == '0)
                        state <= PICK;
                    else
                        settle_cnt <= settle_cnt - 1'b1;
                end
                default: state <= PICK;
            endcase
        end
    end

endmodule
